// File: rtl/arith_unit_seq.sv
// Sequential add/sub/mul/div unit on two unsigned W-bit operands.
// Multiply is shift-add and divide is restoring, one bit per clock.
module arith_unit_seq #(
    parameter int unsigned W = 8
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    input  logic [1:0]       iOp,
    input  logic [W-1:0]     iA,
    input  logic [W-1:0]     iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [2*W-1:0]   oResult,
    output logic             oFlag
);

    localparam int unsigned CW = $clog2(W);

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpMul = 2'b10;
    localparam logic [1:0] OpDiv = 2'b11;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic [1:0]      op_q;
    logic [W-1:0]    a_q;       // dividend shifts out, quotient shifts in
    logic [W-1:0]    b_q;       // multiplier shifts right during mul
    logic [2*W-1:0]  acc_q;
    logic [2*W-1:0]  mcand_q;
    logic [W-1:0]    rem_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic [2*W-1:0]  result_q;
    logic            flag_q;

    logic [2*W-1:0]  mul_acc_next;
    logic [W:0]      rem_shift;
    logic [W-1:0]    rem_diff;
    logic            div_ge;
    logic [W-1:0]    rem_next;
    logic [W-1:0]    quo_next;
    logic [W:0]      sum;
    logic [W-1:0]    diff;
    logic [2*W-1:0]  final_res;
    logic            final_flag;

    always_comb begin
        mul_acc_next = b_q[0] ? acc_q + mcand_q : acc_q;

        // Remainder gets one extra bit so the trial compare cannot overflow.
        rem_shift = {rem_q, a_q[W-1]};
        div_ge    = rem_shift >= {1'b0, b_q};
        rem_diff  = rem_shift[W-1:0] - b_q;
        rem_next  = div_ge ? rem_diff : rem_shift[W-1:0];
        quo_next  = {a_q[W-2:0], div_ge};

        sum  = {1'b0, a_q} + {1'b0, b_q};
        diff = a_q - b_q;

        final_res  = '0;
        final_flag = 1'b0;
        unique case (op_q)
            OpAdd: begin
                final_res  = {{(W-1){1'b0}}, sum};
                final_flag = sum[W];
            end
            OpSub: begin
                final_res  = {{W{1'b0}}, diff};
                final_flag = a_q < b_q;
            end
            OpMul: begin
                final_res  = mul_acc_next;
                final_flag = 1'b0;
            end
            OpDiv: begin
                // A zero divisor naturally yields all-ones quotient and remainder = dividend.
                final_res  = {rem_next, quo_next};
                final_flag = (b_q == '0);
            end
            default: begin
                final_res  = '0;
                final_flag = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            flag_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (iStart) begin
                        op_q    <= iOp;
                        a_q     <= iA;
                        b_q     <= iB;
                        acc_q   <= '0;
                        mcand_q <= {{W{1'b0}}, iA};
                        rem_q   <= '0;
                        cnt_q   <= iOp[1] ? CW'(W - 1) : '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (op_q == OpMul) begin
                        acc_q   <= mul_acc_next;
                        mcand_q <= mcand_q << 1;
                        b_q     <= b_q >> 1;
                    end
                    if (op_q == OpDiv) begin
                        a_q   <= quo_next;
                        rem_q <= rem_next;
                    end
                    if (cnt_q == '0) begin
                        result_q <= final_res;
                        flag_q   <= final_flag;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign oBusy   = busy_q;
    assign oDone   = done_q;
    assign oResult = result_q;
    assign oFlag   = flag_q;

endmodule

// File: tb/tb_arith_unit_seq.sv
// Bench for arith_unit_seq: a cycle-level reference model compared every cycle,
// plus directed operations with literal expected results and latencies.
module tb_arith_unit_seq;

    localparam int W = 8;
    localparam int M = 1 << W;

    logic             iClk = 1'b0;
    logic             iRst_n = 1'b0;
    logic             iStart = 1'b0;
    logic [1:0]       iOp = 2'b00;
    logic [W-1:0]     iA = '0;
    logic [W-1:0]     iB = '0;
    logic             oBusy;
    logic             oDone;
    logic [2*W-1:0]   oResult;
    logic             oFlag;

    int nchecks = 0;
    int nerr = 0;

    arith_unit_seq #(.W(W)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iStart (iStart),
        .iOp    (iOp),
        .iA     (iA),
        .iB     (iB),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oResult(oResult),
        .oFlag  (oFlag)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Returns {flag, result} computed with plain integer arithmetic.
    function automatic logic [2*W:0] model_op(input logic [1:0] op, input int unsigned a,
                                              input int unsigned b);
        int unsigned r;
        logic f;
        case (op)
            2'b00: begin r = a + b; f = (a + b) >= M; end
            2'b01: begin r = (a + M - b) % M; f = a < b; end
            2'b10: begin r = a * b; f = 1'b0; end
            default: begin
                if (b == 0) begin r = a * M + (M - 1); f = 1'b1; end
                else begin r = (a % b) * M + a / b; f = 1'b0; end
            end
        endcase
        return {f, r[2*W-1:0]};
    endfunction

    logic           m_busy = 1'b0;
    logic           m_done = 1'b0;
    logic           m_flag = 1'b0;
    logic [2*W-1:0] m_res = '0;
    logic [2*W:0]   m_pend = '0;
    int             m_left = 0;

    always @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_flag <= 1'b0;
            m_res  <= '0;
            m_left <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_res  <= m_pend[2*W-1:0];
                m_flag <= m_pend[2*W];
            end
            m_left <= m_left - 1;
        end else if (iStart) begin
            m_busy <= 1'b1;
            m_left <= (iOp[1] ? W + 1 : 2) - 1;
            m_pend <= model_op(iOp, iA, iB);
        end
    end

    always @(negedge iClk) begin
        check("busy", oBusy, m_busy);
        check("done", oDone, m_done);
        check("result", oResult, m_res);
        check("flag", oFlag, m_flag);
    end

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] er, input logic ef, input int elat);
        int cyc;
        bit seen;
        @(negedge iClk);
        iOp = op; iA = a; iB = b; iStart = 1'b1;
        @(posedge iClk);
        #1 iStart = 1'b0;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 20) begin
            @(negedge iClk);
            cyc++;
            if (oDone) seen = 1;
        end
        check("done seen", seen, 1);
        if (seen) begin
            check("latency", cyc, elat);
            check("op result", oResult, er);
            check("op flag", oFlag, ef);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*W-1:0] q[$];
        int ndone;

        repeat (3) @(negedge iClk);
        check("reset busy", oBusy, 0);
        check("reset done", oDone, 0);
        check("reset result", oResult, 0);
        iRst_n = 1'b1;

        run_op(2'b00, 8'd200, 8'd100, 16'h012C, 1'b1, 2);
        run_op(2'b00, 8'd3,   8'd4,   16'h0007, 1'b0, 2);
        run_op(2'b01, 8'd5,   8'd9,   16'h00FC, 1'b1, 2);
        run_op(2'b01, 8'd9,   8'd5,   16'h0004, 1'b0, 2);
        run_op(2'b10, 8'd255, 8'd255, 16'hFE01, 1'b0, 9);
        run_op(2'b10, 8'd0,   8'd77,  16'h0000, 1'b0, 9);
        run_op(2'b11, 8'd200, 8'd7,   16'h041C, 1'b0, 9);
        run_op(2'b11, 8'd13,  8'd0,   16'h0DFF, 1'b1, 9);

        // iStart held high with iA changing every cycle: only idle edges accept.
        @(negedge iClk);
        iOp = 2'b00; iB = '0; iA = 8'd0; iStart = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            @(negedge iClk);
            if (oDone) q.push_back(oResult);
            iA = W'(j);
        end
        @(negedge iClk);
        iStart = 1'b0;
        repeat (4) @(negedge iClk);
        check("stream count", q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < q.size()) check("stream result", q[i], i * 3);
        end

        // Reset in cycle 4 of a multiply, after a non-zero result is on the outputs.
        run_op(2'b11, 8'd13, 8'd0, 16'h0DFF, 1'b1, 9);
        @(negedge iClk);
        iOp = 2'b10; iA = 8'd255; iB = 8'd255; iStart = 1'b1;
        @(posedge iClk);
        #1 iStart = 1'b0;
        repeat (4) @(negedge iClk);
        iRst_n = 1'b0;
        #1;
        check("abort busy", oBusy, 0);
        check("abort done", oDone, 0);
        check("abort result", oResult, 0);
        check("abort flag", oFlag, 0);
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;
        ndone = 0;
        repeat (15) begin
            @(negedge iClk);
            if (oDone) ndone++;
        end
        check("no done after abort", ndone, 0);
        run_op(2'b00, 8'd3, 8'd4, 16'h0007, 1'b0, 2);

        repeat (2) @(negedge iClk);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/arith_unit_seq.md
# arith_unit_seq

Parametrised, sequential arithmetic unit: add, subtract, multiply and divide on two unsigned W-bit operands, selected by an opcode latched at start. Multiply (shift-add) and divide (restoring) are iterative, one bit per clock. A start/busy/done handshake lets a controller issue one operation at a time. This is the next generation of the team's combinational 4-bit operation block and serves as the shared arithmetic resource in datapath designs.

## Interface
- W, 8: operand width in bits, W ≥ 2.
- iClk  input  1  clock; all state changes on the rising edge.
- iRst_n  input  1  asynchronous, active-low reset.
- iStart  input  1  request; accepted only when oBusy = 0.
- iOp  input  2  opcode, sampled at accept: 00 add, 01 sub, 10 mul, 11 div.
- iA  input  W  first operand (unsigned), sampled at accept.
- iB  input  W  second operand (unsigned), sampled at accept.
- oBusy  output  1  high from the cycle after accept through the oDone cycle, inclusive.
- oDone  output  1  one-cycle pulse; oResult and oFlag are valid from this cycle.
- oResult  output  2W  result; holds until the next oDone.
- oFlag  output  1  add: carry out; sub: borrow (iA < iB); mul: 0; div: divide-by-zero.

## Operation
- Accept: rising edge with iStart = 1 and oBusy = 0. Latch iA, iB and iOp, and enter RUN. iStart while oBusy = 1 is ignored, with no queuing.
- States:
  - IDLE: wait for accept. On accept, go to RUN.
  - RUN: iterate. When the cycle count is reached, go to DONE.
  - DONE: write oResult and oFlag, pulse oDone, go to IDLE.
- Add: oResult = zero-extended (iA + iB), W+1 significant bits. oFlag = bit W of the sum.
- Sub: oResult[W-1:0] = (iA − iB) mod 2^W, and oResult[2W-1:W] = 0. oFlag = 1 iff iA < iB.
- Mul: full 2W-bit product by shift-add, W iterations. oFlag = 0.
- Div: restoring division, W iterations. oResult[W-1:0] = quotient and oResult[2W-1:W] = remainder.
- Divide by zero (iB = 0 at accept): quotient = all ones, remainder = iA, oFlag = 1. Latency is the same as a normal divide.
- Reset, including mid-operation: abort immediately. Return to IDLE with oBusy = 0, oDone = 0, oResult = 0 and oFlag = 0. Latched operands are discarded.
- oResult and oFlag change only in the oDone cycle. Between operations they hold the last result.

## Timing
- Accept edge is cycle 0.
- Add/sub: RUN lasts 1 cycle. oDone is high in cycle 2, so latency is 2.
- Mul/div: RUN lasts W cycles (iteration counter W−1 down to 0). oDone is high in cycle W+1, so latency is W+1; for W=8 that is cycle 9.
- oBusy is high from cycle 1 through the oDone cycle.
- Back-to-back: iStart held high in the oDone cycle is not accepted, because oBusy = 1. The earliest next accept is the edge after oDone, which gives a throughput of 1 op per latency+1 cycles.
- Every output is 0 while iRst_n = 0. iRst_n deasserting is not synchronised internally; the release must meet recovery/removal at iClk.

## Test plan (W = 8)
- Add 200 + 100: oDone 2 cycles after accept, oResult = 0x012C, oFlag = 1. Add 3 + 4: oResult = 0x0007, oFlag = 0.
- Sub 5 − 9: oResult = 0x00FC, oFlag = 1. Sub 9 − 5: oResult = 0x0004, oFlag = 0.
- Mul 255 × 255: oDone exactly 9 cycles after accept, oResult = 0xFE01, oFlag = 0. Mul 0 × 77: oResult = 0x0000.
- Div 200 / 7: oResult = 0x041C (remainder 4, quotient 28), oFlag = 0. Div 13 / 0: oResult = 0x0DFF, oFlag = 1, latency 9.
- Hold iStart high continuously with changing iA: only the operands present at each accept are used, and no accept occurs while oBusy = 1. Each oDone is a single cycle.
- Assert iRst_n = 0 in cycle 4 of a multiply: all outputs are 0 immediately and no oDone follows. A new add issued after release completes normally.
